counter_bank: RTL and testbench
===============================

Name: counter_bank

Overview:
- Parametrised multi-channel up/down counter bank; next generation of the team's single-channel overflow counter.
- Adds per-channel direction, programmable limit (modulo), wrap or saturate mode, parallel load, terminal-count pulse and sticky overflow/underflow flags with clear.
- Used as an event/statistics counter block beside the datapath; all outputs are registered.

Parameters:
- NCH, 4, number of independent counter channels (>=1).
- W, 32, counter width per channel in bits (>=2).

Ports:
- clk  input  1  clock, all logic on rising edge.
- reset_n  input  1  synchronous, active-low reset.
- en  input  NCH  per-channel count enable.
- up  input  NCH  per-channel direction, 1 = increment, 0 = decrement.
- sat_mode  input  NCH  per-channel mode, 1 = saturate, 0 = wrap.
- load  input  NCH  per-channel parallel load strobe.
- load_val  input  NCH*W  load values, channel i at bits [i*W +: W].
- limit  input  NCH*W  inclusive maximum count per channel, same packing.
- clr_flags  input  NCH  clears the sticky flags of a channel.
- count  output  NCH*W  current count values, same packing.
- tc  output  NCH  one-cycle pulse on an overflow or underflow event.
- ovf  output  NCH  sticky overflow flag.
- unf  output  NCH  sticky underflow flag.

Behaviour:
- Reset: reset_n is synchronous and active-low, clock is clk. While reset_n=0 at a clk edge, count, tc, ovf and unf all go to 0. Reset overrides all other inputs, including a reset asserted mid-count.
- Latency: one cycle. Inputs sampled at edge k are reflected in the outputs after edge k.

Per-channel priority per cycle: load > en > hold.
- load=1:
  - count <= min(load_val, limit), so out-of-range loads are clamped to limit.
  - tc=0; flags are unaffected by the load.
- en=1 and up=1:
  - If count >= limit, this is an overflow event: count <= 0 in wrap mode, count <= limit in saturate mode.
  - Otherwise count <= count+1.
- en=1 and up=0:
  - If count == 0, this is an underflow event: count <= limit in wrap mode, count <= 0 in saturate mode.
  - Otherwise count <= count-1.
- en=0: count holds.

Event outputs:
- tc=1 for exactly the cycle following an event; 0 otherwise.
- In saturate mode, every enabled cycle at the boundary is an event, so tc stays high while the channel is pinned.
- ovf is set on an overflow event; unf is set on an underflow event.
- clr_flags clears both flags. If a set and a clear happen in the same cycle, the set wins.

Boundary conditions:
- limit=0: an up count always overflows; in wrap mode count stays 0 and tc pulses every enabled cycle.
- limit lowered below the current count: the next up step is treated as an overflow. The next down step decrements normally.
- count never exceeds limit except in the case above.
- All comparisons are unsigned W-bit. No carry bit is exposed, and +1/-1 never wraps the raw W-bit register.
- Channels are fully independent, with no shared state between them.

Decomposition:
- Package counter_pkg holds:
  - typedef cnt_mode_e {CNT_WRAP=0, CNT_SAT=1};
  - typedef cnt_evt_e {EVT_NONE, EVT_OVF, EVT_UNF};
  - a function computing the next count and event from (count, limit, up, mode).
- Sub-module counter_chan: one channel with W-bit state, tc and flags. counter_bank is a generate loop of NCH counter_chan instances plus port packing/unpacking.

Test Plan (all with W=8, NCH=4):
- Wrap up: ch0 sat_mode=0, limit=5, en=1, up=1 from 0 for 7 cycles -> count 1,2,3,4,5,0,1; tc high only on the cycle count returns to 0; ovf=1 from then on.
- Saturate down: ch1 sat_mode=1, load_val=2, then up=0 for 4 cycles -> count 1,0,0,0; tc high on both cycles pinned at 0; unf=1.
- Load clamp and priority: ch2 limit=10, load=1, load_val=200, en=1 in the same cycle -> count=10, tc=0, flags unchanged.
- Flag set/clear race: ch3 at count=limit=3, en=1, up=1, clr_flags=1 in the same cycle -> count=0, ovf=1 (set wins); clr_flags alone next cycle -> ovf=0.
- Limit change and limit=0: ch0 count=9, limit changed to 4, up step -> count=0 with ovf event. Then limit=0 with en held -> count stays 0 and tc=1 every cycle.
- Reset mid-operation: all channels counting, reset_n=0 for 1 cycle -> all count, tc, ovf, unf = 0 after that edge; counting resumes from 0 on the next edge; channels verified independent throughout.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared types and next-count arithmetic for the counter bank.
// Values are carried zero-extended to CNT_MAXW bits so one function serves every width.
package counter_pkg;

   localparam int unsigned CNT_MAXW = 64;

   typedef enum logic {
      CNT_WRAP = 1'b0,
      CNT_SAT  = 1'b1
   } cnt_mode_e;

   typedef enum logic [1:0] {
      EVT_NONE,
      EVT_OVF,
      EVT_UNF
   } cnt_evt_e;

   typedef logic [CNT_MAXW-1:0] cnt_word_t;

   typedef struct packed {
      cnt_word_t cnt;
      cnt_evt_e  evt;
   } cnt_step_t;

   // +1 only happens below lim and -1 only above zero, so the result
   // never leaves the caller's W-bit range.
   function automatic cnt_step_t cnt_next(
      input cnt_word_t cnt,
      input cnt_word_t lim,
      input logic      up,
      input cnt_mode_e mode
   );
      cnt_step_t s;
      s.cnt = cnt;
      s.evt = EVT_NONE;
      if (up) begin
         if (cnt >= lim) begin
            s.evt = EVT_OVF;
            s.cnt = (mode == CNT_SAT) ? lim : '0;
         end else begin
            s.cnt = cnt + cnt_word_t'(1);
         end
      end else begin
         if (cnt == '0) begin
            s.evt = EVT_UNF;
            s.cnt = (mode == CNT_SAT) ? '0 : lim;
         end else begin
            s.cnt = cnt - cnt_word_t'(1);
         end
      end
      return s;
   endfunction

endpackage

// File: rtl/counter_chan.sv
// One counter channel: W-bit count, terminal-count pulse, sticky flags.
// Priority per cycle is load, then enable, then hold.
module counter_chan
   import counter_pkg::*;
#(
   parameter int unsigned W = 32
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         en,
   input  logic         up,
   input  logic         sat_mode,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic [W-1:0] limit,
   input  logic         clr_flags,
   output logic [W-1:0] count,
   output logic         tc,
   output logic         ovf,
   output logic         unf
);

   logic [W-1:0] count_q, count_d;
   logic         tc_q, tc_d;
   logic         ovf_q, ovf_d;
   logic         unf_q, unf_d;
   cnt_step_t    step;

   always_comb begin
      step = cnt_next(cnt_word_t'(count_q), cnt_word_t'(limit),
                      up, cnt_mode_e'(sat_mode));
   end

   // A set in the same cycle overrides the clear.
   always_comb begin
      count_d = count_q;
      tc_d    = 1'b0;
      ovf_d   = ovf_q & ~clr_flags;
      unf_d   = unf_q & ~clr_flags;
      if (load) begin
         count_d = (load_val > limit) ? limit : load_val;
      end else if (en) begin
         count_d = step.cnt[W-1:0];
         tc_d    = (step.evt != EVT_NONE);
         if (step.evt == EVT_OVF) ovf_d = 1'b1;
         if (step.evt == EVT_UNF) unf_d = 1'b1;
      end
   end

   if (W < CNT_MAXW) begin : g_hi_chk
      always_comb begin
         assert (step.cnt[CNT_MAXW-1:W] == '0);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         count_q <= '0;
         tc_q    <= 1'b0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         tc_q    <= tc_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

   assign count = count_q;
   assign tc    = tc_q;
   assign ovf   = ovf_q;
   assign unf   = unf_q;

endmodule

// File: rtl/counter_bank.sv
// Bank of NCH independent up/down counters with limit, mode and flags.
// Channel i occupies bits [i*W +: W] of every packed vector.
module counter_bank
   import counter_pkg::*;
#(
   parameter int unsigned NCH = 4,
   parameter int unsigned W   = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [NCH-1:0]   en,
   input  logic [NCH-1:0]   up,
   input  logic [NCH-1:0]   sat_mode,
   input  logic [NCH-1:0]   load,
   input  logic [NCH*W-1:0] load_val,
   input  logic [NCH*W-1:0] limit,
   input  logic [NCH-1:0]   clr_flags,
   output logic [NCH*W-1:0] count,
   output logic [NCH-1:0]   tc,
   output logic [NCH-1:0]   ovf,
   output logic [NCH-1:0]   unf
);

   for (genvar i = 0; i < NCH; i++) begin : g_chan
      counter_chan #(
         .W(W)
      ) u_chan (
         .clk       (clk),
         .reset_n   (reset_n),
         .en        (en[i]),
         .up        (up[i]),
         .sat_mode  (sat_mode[i]),
         .load      (load[i]),
         .load_val  (load_val[i*W +: W]),
         .limit     (limit[i*W +: W]),
         .clr_flags (clr_flags[i]),
         .count     (count[i*W +: W]),
         .tc        (tc[i]),
         .ovf       (ovf[i]),
         .unf       (unf[i])
      );
   end

endmodule

// File: tb/tb_counter_bank.sv
// Bench for counter_bank: directed scenarios plus random traffic
// against an integer-arithmetic reference of each channel.
module tb_counter_bank;

   localparam int NCH = 4;
   localparam int W   = 8;

   logic             clk = 1'b0;
   logic             reset_n;
   logic [NCH-1:0]   en, up, sat_mode, load, clr_flags;
   logic [NCH*W-1:0] load_val, limit;
   logic [NCH*W-1:0] count;
   logic [NCH-1:0]   tc, ovf, unf;

   int n_vec = 0;
   int n_bad = 0;

   int m_cnt [NCH];
   bit m_tc  [NCH];
   bit m_ovf [NCH];
   bit m_unf [NCH];

   counter_bank #(.NCH(NCH), .W(W)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .en        (en),
      .up        (up),
      .sat_mode  (sat_mode),
      .load      (load),
      .load_val  (load_val),
      .limit     (limit),
      .clr_flags (clr_flags),
      .count     (count),
      .tc        (tc),
      .ovf       (ovf),
      .unf       (unf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      n_vec++;
      if (obs != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int cnt_of(input int i);
      return int'(count[i*W +: W]);
   endfunction

   // Channel behaviour expressed directly with integers.
   task automatic model_edge();
      for (int i = 0; i < NCH; i++) begin
         int c, l, lv;
         bit o, u;
         c = m_cnt[i];
         l = int'(limit[i*W +: W]);
         lv = int'(load_val[i*W +: W]);
         if (!reset_n) begin
            m_cnt[i] = 0; m_tc[i] = 0; m_ovf[i] = 0; m_unf[i] = 0;
         end else begin
            o = m_ovf[i] && !clr_flags[i];
            u = m_unf[i] && !clr_flags[i];
            m_tc[i] = 0;
            if (load[i]) begin
               m_cnt[i] = (lv < l) ? lv : l;
            end else if (en[i]) begin
               if (up[i]) begin
                  if (c >= l) begin
                     m_tc[i] = 1; o = 1;
                     m_cnt[i] = sat_mode[i] ? l : 0;
                  end else m_cnt[i] = c + 1;
               end else begin
                  if (c == 0) begin
                     m_tc[i] = 1; u = 1;
                     m_cnt[i] = sat_mode[i] ? 0 : l;
                  end else m_cnt[i] = c - 1;
               end
            end
            m_ovf[i] = o;
            m_unf[i] = u;
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      for (int i = 0; i < NCH; i++) begin
         chk($sformatf("cnt%0d", i), cnt_of(i), m_cnt[i]);
         chk($sformatf("tc%0d", i), int'(tc[i]), int'(m_tc[i]));
         chk($sformatf("ovf%0d", i), int'(ovf[i]), int'(m_ovf[i]));
         chk($sformatf("unf%0d", i), int'(unf[i]), int'(m_unf[i]));
      end
   endtask

   task automatic idle_all();
      en = '0; up = '0; sat_mode = '0; load = '0; clr_flags = '0;
   endtask

   initial begin
      int exp_w [7];
      int exp_s [4];
      int exp_st[4];
      exp_w  = '{1, 2, 3, 4, 5, 0, 1};
      exp_s  = '{1, 0, 0, 0};
      exp_st = '{0, 0, 1, 1};

      reset_n = 1'b0;
      idle_all();
      load_val = '0;
      limit = '0;
      for (int i = 0; i < NCH; i++) m_cnt[i] = 0;
      step();
      for (int i = 0; i < NCH; i++) chk("rst_cnt", cnt_of(i), 0);
      reset_n = 1'b1;

      // Wrap up on ch0
      limit[0 +: W] = 8'd5; en[0] = 1; up[0] = 1;
      for (int k = 0; k < 7; k++) begin
         step();
         chk("wrap_cnt", cnt_of(0), exp_w[k]);
         chk("wrap_tc", int'(tc[0]), (k == 5) ? 1 : 0);
      end
      chk("wrap_ovf", int'(ovf[0]), 1);
      idle_all();

      // Saturate down on ch1
      sat_mode[1] = 1; limit[W +: W] = 8'd10;
      load[1] = 1; load_val[W +: W] = 8'd2;
      step();
      chk("sat_load", cnt_of(1), 2);
      load[1] = 0; en[1] = 1; up[1] = 0;
      for (int k = 0; k < 4; k++) begin
         step();
         chk("sat_cnt", cnt_of(1), exp_s[k]);
         chk("sat_tc", int'(tc[1]), exp_st[k]);
      end
      chk("sat_unf", int'(unf[1]), 1);
      idle_all();

      // Load clamp beats enable on ch2
      limit[2*W +: W] = 8'd10; load_val[2*W +: W] = 8'd200;
      load[2] = 1; en[2] = 1; up[2] = 1;
      step();
      chk("clamp_cnt", cnt_of(2), 10);
      chk("clamp_tc", int'(tc[2]), 0);
      chk("clamp_ovf", int'(ovf[2]), 0);
      idle_all();

      // Set/clear race on ch3
      limit[3*W +: W] = 8'd3; load_val[3*W +: W] = 8'd3; load[3] = 1;
      step();
      load[3] = 0; en[3] = 1; up[3] = 1; clr_flags[3] = 1;
      step();
      chk("race_cnt", cnt_of(3), 0);
      chk("race_ovf", int'(ovf[3]), 1);
      en[3] = 0;
      step();
      chk("clr_ovf", int'(ovf[3]), 0);
      idle_all();

      // Limit lowered below count, then limit=0 on ch0
      limit[0 +: W] = 8'd20; load_val[0 +: W] = 8'd9; load[0] = 1;
      step();
      load[0] = 0; limit[0 +: W] = 8'd4; en[0] = 1; up[0] = 0;
      step();
      chk("low_dn", cnt_of(0), 8);
      en[0] = 0; limit[0 +: W] = 8'd20; load[0] = 1;
      step();
      load[0] = 0; limit[0 +: W] = 8'd4; en[0] = 1; up[0] = 1;
      step();
      chk("low_up", cnt_of(0), 0);
      chk("low_tc", int'(tc[0]), 1);
      limit[0 +: W] = 8'd0;
      for (int k = 0; k < 3; k++) begin
         step();
         chk("lim0_cnt", cnt_of(0), 0);
         chk("lim0_tc", int'(tc[0]), 1);
      end
      idle_all();

      // Reset mid-count
      limit = {NCH{8'd50}}; en = '1; up = '1;
      repeat (3) step();
      reset_n = 1'b0;
      step();
      for (int i = 0; i < NCH; i++) begin
         chk("mrst_cnt", cnt_of(i), 0);
         chk("mrst_flg", int'({tc[i], ovf[i], unf[i]}), 0);
      end
      reset_n = 1'b1;
      step();
      for (int i = 0; i < NCH; i++) chk("resume", cnt_of(i), 1);

      // Random traffic
      for (int k = 0; k < 400; k++) begin
         reset_n = ($urandom_range(0, 59) != 0);
         en = NCH'($urandom);
         up = NCH'($urandom);
         sat_mode = NCH'($urandom);
         load = '0; clr_flags = '0;
         for (int i = 0; i < NCH; i++) begin
            load[i] = ($urandom_range(0, 7) == 0);
            clr_flags[i] = ($urandom_range(0, 7) == 0);
            load_val[i*W +: W] = ($urandom_range(0, 9) == 0) ? 8'hff :
                                 8'($urandom_range(0, 20));
            if ($urandom_range(0, 9) == 0)
               limit[i*W +: W] = ($urandom_range(0, 7) == 0) ? 8'hff :
                                 8'($urandom_range(0, 12));
         end
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
